// File: rtl/sseg_pkg.sv
// sseg_pkg: shared scan-controller types, digit-count limits and width helper
package sseg_pkg;
  typedef enum logic [1:0] {OFF, SHOW, GAP} state_t;
  localparam int NUM_DIGITS_DEF = 4;
  localparam int MAX_DIGITS = 8;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/sseg_dwell_timer.sv
// sseg_dwell_timer: loadable down-counter whose done flags the last cycle (count 1)
module sseg_dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (count && cnt != '0) cnt <= cnt - W'(1);
  end
  assign done = cnt == W'(1);
endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: multiplexed digit scanner with frame-aligned shadow load; SSEG_SCAN_BLANK_EN adds leading-zero blanking
module sseg_scan_ctrl import sseg_pkg::*; #(
  parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
  parameter int DWELL_CYCLES = 1000,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    load_neg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              bcd,
  output logic                    neg,
  output logic                    blank,
  output logic                    frame_done
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(max2(DWELL_CYCLES, GAP_CYCLES) + 1);
  state_t state, nxt;
  logic [IW-1:0] idx, nxt_idx;
  logic [4*NUM_DIGITS-1:0] active_value, shadow_value, nxt_value;
  logic active_neg, active_valid, shadow_neg, shadow_full, nxt_neg;
  logic adv, wrap, copy, tload, tdone, skip;
  logic [CW-1:0] tval;
  logic [3:0] nib;
  assign load_ready = !shadow_full;
  sseg_dwell_timer #(.W(CW)) u_timer (
    .clk(clk),
    .reset(reset),
    .clear(nxt == OFF),
    .load(tload),
    .load_val(tval),
    .count(state != OFF),
    .done(tdone)
  );
  always_comb begin
    nxt = state;
    nxt_idx = idx;
    adv = 1'b0;
    tload = 1'b0;
    tval = CW'(DWELL_CYCLES);
    case (state)
      OFF: if (enable && active_valid) begin
        nxt = SHOW;
        tload = 1'b1;
      end
      SHOW: if (!enable) nxt = OFF;
      else if (tdone) begin
        if (GAP_CYCLES == 0) adv = 1'b1;
        else begin
          nxt = GAP;
          tload = 1'b1;
          tval = CW'(GAP_CYCLES);
        end
      end
      GAP: if (!enable) nxt = OFF;
      else if (tdone) adv = 1'b1;
      default: nxt = OFF;
    endcase
    wrap = adv && idx == IW'(NUM_DIGITS - 1);
    if (adv) begin
      nxt = SHOW;
      tload = 1'b1;
      nxt_idx = wrap ? '0 : idx + IW'(1);
    end
    if (nxt == OFF) nxt_idx = '0;
    copy = shadow_full && (state == OFF || wrap);
    nxt_value = copy ? shadow_value : active_value;
    nxt_neg = copy ? shadow_neg : active_neg;
    nib = '0;
    for (int i = 0; i < NUM_DIGITS; i++) nib = nxt_idx == IW'(i) ? nxt_value[4*i +: 4] : nib;
  end
`ifdef SSEG_SCAN_BLANK_EN
  logic [NUM_DIGITS-1:0] hz;
  logic z;
  // hz[i]: nibbles i..top are all zero
  always_comb begin
    z = 1'b1;
    hz = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z && nxt_value[4*i +: 4] == 4'd0;
      hz[i] = z;
    end
  end
  assign skip = nxt_idx != '0 && hz[nxt_idx];
`else
  assign skip = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= OFF;
      idx <= '0;
    end else begin
      state <= nxt;
      idx <= nxt_idx;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      active_value <= '0;
      active_neg <= 1'b0;
      active_valid <= 1'b0;
      shadow_value <= '0;
      shadow_neg <= 1'b0;
      shadow_full <= 1'b0;
      digit_en <= '0;
      bcd <= '0;
      neg <= 1'b0;
      blank <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (copy) begin
        active_value <= shadow_value;
        active_neg <= shadow_neg;
        active_valid <= 1'b1;
        shadow_full <= 1'b0;
      end
      if (load_valid && load_ready) begin
        shadow_value <= load_value;
        shadow_neg <= load_neg;
        shadow_full <= 1'b1;
      end
      frame_done <= wrap;
      digit_en <= nxt == SHOW && !skip ? NUM_DIGITS'(1) << nxt_idx : '0;
      blank <= nxt == SHOW ? skip : nxt == GAP && blank;
      if (nxt == SHOW) begin
        bcd <= nib;
        neg <= nxt_neg;
      end
    end
  end
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: randomized self-checking bench against a frame-position reference model
module tb_sseg_scan_ctrl;
  localparam int N = 4;
  localparam int D = 4;
  localparam int G = 1;
  localparam int P = N * (D + G);
`ifdef SSEG_SCAN_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, load_valid = 1'b0, load_neg = 1'b0;
  logic [4*N-1:0] load_value = '0;
  logic load_ready, neg, blank, frame_done;
  logic [N-1:0] digit_en;
  logic [3:0] bcd;
  int n_vec = 0, n_err = 0, cyc = 0;
  logic [15:0] a_val, s_val;
  bit a_neg, a_ok, s_neg, s_full, run, m_hs;
  int pos;
  logic [N-1:0] m_den;
  logic [3:0] m_bcd;
  bit m_neg, m_blank, m_fd;
  always #5 clk = ~clk;
  sseg_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_ready(load_ready), .load_value(load_value), .load_neg(load_neg),
    .digit_en(digit_en), .bcd(bcd), .neg(neg), .blank(blank), .frame_done(frame_done)
  );
  // model: one rising edge; the display is derived from the position within the frame
  task automatic tick();
    bit hs, start;
    int slot;
    @(posedge clk);
    cyc++;
    hs = load_valid && !s_full;
    m_fd = 1'b0;
    m_hs = 1'b0;
    if (reset) begin
      a_val = '0; s_val = '0; a_neg = 0; s_neg = 0; a_ok = 0; s_full = 0; run = 0;
      m_den = '0; m_bcd = '0; m_neg = 0; m_blank = 0;
    end else begin
      if (!run) begin
        start = enable && a_ok;
        if (s_full) begin a_val = s_val; a_neg = s_neg; a_ok = 1; s_full = 0; end
        if (start) begin run = 1; pos = 0; end
      end else if (!enable) run = 0;
      else begin
        pos = (pos + 1) % P;
        if (pos == 0) begin
          m_fd = 1'b1;
          if (s_full) begin a_val = s_val; a_neg = s_neg; a_ok = 1; s_full = 0; end
        end
      end
      if (hs) begin s_val = load_value; s_neg = load_neg; s_full = 1; m_hs = 1; end
      if (run) begin
        slot = pos / (D + G);
        m_bcd = 4'((a_val >> (4 * slot)) & 16'hF);
        m_neg = a_neg;
        m_blank = BLANK_EN && slot > 0 && (a_val >> (4 * slot)) == 16'h0;
        m_den = (pos % (D + G) < D && !m_blank) ? N'(1 << slot) : '0;
      end else begin
        m_den = '0;
        m_blank = 0;
      end
    end
    #1;
  endtask
  task automatic apply_reset();
    reset = 1'b1;
    enable = 1'b0;
    load_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask
  task automatic do_load(input logic [15:0] v, input bit ng);
    bit acc = 0;
    load_valid = 1'b1;
    load_value = v;
    load_neg = ng;
    for (int i = 0; i < 40 && !acc; i++) begin
      tick();
      acc = m_hs;
    end
    load_valid = 1'b0;
    n_vec++;
    if (!acc) begin n_err++; $display("FAIL load_accept value %h not accepted within 40 cycles", v); end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    load_valid = 1'b1;
    tick();
    tick();
    load_valid = 1'b0;
    n_vec++; if (digit_en !== '0) begin n_err++; $display("FAIL reset_digit_en got %b want 0", digit_en); end
    n_vec++; if (bcd !== 4'h0) begin n_err++; $display("FAIL reset_bcd got %h want 0", bcd); end
    n_vec++; if (neg !== 1'b0) begin n_err++; $display("FAIL reset_neg got %b want 0", neg); end
    n_vec++; if (blank !== 1'b0) begin n_err++; $display("FAIL reset_blank got %b want 0", blank); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    n_vec++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_load_ready got %b want 1", load_ready); end
    reset = 1'b0;
  endtask
  task automatic test_scan();
    int last = -1;
    apply_reset();
    do_load(16'h1A2F, 1'b1);
    enable = 1'b1;
    for (int k = 0; k < 3 * P + 6; k++) begin
      tick();
      n_vec++;
      if ({digit_en, frame_done, blank, load_ready} !== {m_den, m_fd, m_blank, !s_full}) begin
        n_err++; $display("FAIL scan_strobes got %b %b %b %b want %b %b %b %b cyc %0d", digit_en, frame_done, blank, load_ready, m_den, m_fd, m_blank, !s_full, cyc);
      end
      if (run) begin
        n_vec++;
        if ({bcd, neg} !== {m_bcd, m_neg}) begin n_err++; $display("FAIL scan_data got %h/%b want %h/%b cyc %0d", bcd, neg, m_bcd, m_neg, cyc); end
      end
      if (digit_en == 4'b0100) begin
        n_vec++;
        if (bcd !== 4'hA || neg !== 1'b1) begin n_err++; $display("FAIL scan_digit2 got %h/%b want a/1", bcd, neg); end
      end
      if (frame_done === 1'b1) begin
        if (last >= 0) begin
          n_vec++;
          if (cyc - last != P) begin n_err++; $display("FAIL scan_period got %0d want %0d", cyc - last, P); end
        end
        last = cyc;
      end
    end
  endtask
  task automatic test_shadow();
    bit seen = 0;
    apply_reset();
    do_load(16'h1234, 1'b0);
    enable = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    do_load(16'h5678, 1'b1);
    n_vec++;
    if (load_ready !== 1'b0) begin n_err++; $display("FAIL shadow_ready_drop got %b want 0", load_ready); end
    for (int k = 0; k < 2 * P; k++) begin
      tick();
      n_vec++;
      if ({digit_en, frame_done, load_ready} !== {m_den, m_fd, !s_full}) begin
        n_err++; $display("FAIL shadow_strobes got %b %b %b want %b %b %b cyc %0d", digit_en, frame_done, load_ready, m_den, m_fd, !s_full, cyc);
      end
      if (run) begin
        n_vec++;
        if ({bcd, neg} !== {m_bcd, m_neg}) begin n_err++; $display("FAIL shadow_data got %h/%b want %h/%b cyc %0d", bcd, neg, m_bcd, m_neg, cyc); end
      end
      if (frame_done === 1'b1 && !seen) begin
        seen = 1;
        n_vec++;
        if ({load_ready, bcd, neg} !== {1'b1, 4'h8, 1'b1}) begin n_err++; $display("FAIL shadow_boundary got %b/%h/%b want 1/8/1", load_ready, bcd, neg); end
      end
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL shadow_frame_done got none want pulse"); end
  endtask
  task automatic test_enable();
    bit hit = 0;
    apply_reset();
    do_load(16'hC3B7, 1'b0);
    enable = 1'b1;
    for (int k = 0; k < 60 && !hit; k++) begin
      tick();
      hit = digit_en == 4'b0100;
    end
    n_vec++;
    if (!hit) begin n_err++; $display("FAIL enable_reach_digit2 got %b want 0100", digit_en); end
    enable = 1'b0;
    tick();
    n_vec++;
    if ({digit_en, frame_done} !== 5'b0) begin n_err++; $display("FAIL enable_off got %b/%b want 0/0", digit_en, frame_done); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (digit_en !== m_den) begin n_err++; $display("FAIL enable_idle got %b want %b", digit_en, m_den); end
    end
    enable = 1'b1;
    for (int k = 0; k < D + G; k++) begin
      tick();
      n_vec++;
      if (digit_en !== (k < D ? 4'b0001 : 4'b0000) || digit_en !== m_den) begin
        n_err++; $display("FAIL enable_restart got %b want %b step %0d", digit_en, k < D ? 4'b0001 : 4'b0000, k);
      end
    end
  endtask
  task automatic test_reset_mid();
    bit hit = 0;
    apply_reset();
    do_load(16'h4321, 1'b0);
    enable = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    do_load(16'h9999, 1'b1);
    for (int k = 0; k < 20 && !hit; k++) begin
      tick();
      hit = run && pos % (D + G) == D && s_full;
    end
    n_vec++;
    if (!hit) begin n_err++; $display("FAIL resetmid_reach_gap got none want gap with full shadow"); end
    reset = 1'b1;
    load_valid = 1'b1;
    tick();
    reset = 1'b0;
    load_valid = 1'b0;
    n_vec++;
    if ({digit_en, bcd, neg, blank, frame_done, load_ready} !== {4'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL resetmid_outputs got %b %h %b %b %b %b want 0 0 0 0 0 1", digit_en, bcd, neg, blank, frame_done, load_ready);
    end
    for (int k = 0; k < 30; k++) begin
      tick();
      n_vec++;
      if (digit_en !== 4'b0 || digit_en !== m_den) begin n_err++; $display("FAIL resetmid_dark got %b want 0000", digit_en); end
    end
    do_load(16'h0246, 1'b0);
    hit = 0;
    for (int k = 0; k < 6 && !hit; k++) begin
      tick();
      hit = digit_en == 4'b0001 && bcd == 4'h6;
    end
    n_vec++;
    if (!hit) begin n_err++; $display("FAIL resetmid_resume got %b/%h want 0001/6", digit_en, bcd); end
  endtask
  task automatic test_random();
    apply_reset();
    do_load(16'($urandom), 1'($urandom));
    for (int k = 0; k < 800; k++) begin
      load_valid = $urandom_range(0, 9) == 0;
      load_value = $urandom_range(0, 2) == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom);
      load_neg = 1'($urandom);
      enable = $urandom_range(0, 39) != 0;
      reset = $urandom_range(0, 299) == 0;
      tick();
      n_vec++;
      if ({digit_en, frame_done, blank, load_ready} !== {m_den, m_fd, m_blank, !s_full}) begin
        n_err++; $display("FAIL random_strobes got %b %b %b %b want %b %b %b %b cyc %0d", digit_en, frame_done, blank, load_ready, m_den, m_fd, m_blank, !s_full, cyc);
      end
      if (run) begin
        n_vec++;
        if ({bcd, neg} !== {m_bcd, m_neg}) begin n_err++; $display("FAIL random_data got %h/%b want %h/%b cyc %0d", bcd, neg, m_bcd, m_neg, cyc); end
      end
    end
    reset = 1'b0;
    load_valid = 1'b0;
  endtask
`ifdef SSEG_SCAN_BLANK_EN
  task automatic test_blank();
    int last = -1;
    apply_reset();
    do_load(16'h0005, 1'b0);
    enable = 1'b1;
    for (int k = 0; k < 2 * P + 4; k++) begin
      tick();
      n_vec++;
      if ({digit_en, blank, bcd} !== {m_den, m_blank, m_bcd}) begin
        n_err++; $display("FAIL blank_scan got %b %b %h want %b %b %h cyc %0d", digit_en, blank, bcd, m_den, m_blank, m_bcd, cyc);
      end
      if (run && pos / (D + G) > 0) begin
        n_vec++;
        if (blank !== 1'b1 || digit_en !== 4'b0) begin n_err++; $display("FAIL blank_upper got %b/%b want 1/0000", blank, digit_en); end
      end
      if (frame_done === 1'b1) begin
        if (last >= 0) begin
          n_vec++;
          if (cyc - last != P) begin n_err++; $display("FAIL blank_period got %0d want %0d", cyc - last, P); end
        end
        last = cyc;
      end
    end
  endtask
  task automatic test_blank_zero();
    bit hit = 0;
    apply_reset();
    do_load(16'h0000, 1'b0);
    enable = 1'b1;
    for (int k = 0; k < 6 && !hit; k++) begin
      tick();
      hit = digit_en == 4'b0001;
    end
    n_vec++;
    if (!hit || blank !== 1'b0 || bcd !== 4'h0) begin n_err++; $display("FAIL blank_zero got %b/%b/%h want 0001/0/0", digit_en, blank, bcd); end
  endtask
`endif
  initial begin
    test_reset();
    test_scan();
    test_shadow();
    test_enable();
    test_reset_mid();
`ifdef SSEG_SCAN_BLANK_EN
    test_blank();
    test_blank_zero();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
